// File: rtl/io_bus_arbiter_if.sv
// Request/response bundle between one IO bus master and the arbiter.
// The master drives req/we/addr/wdata and receives a one-cycle ack plus the held read data.
interface io_bus_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing the IO bus between two masters, with fixed wait states
// and a decoded timer window steered to mtime_we / mtime_dout.
//
// state  | meaning
// IDLE   | no access in flight; a request here is granted and latched
// ACCESS | bus cycle of WAIT_CYCLES+1 clocks; strobes on the first, read capture on the last
// DONE   | one-cycle ack to the granted master; requests are ignored
module io_bus_arbiter #(
    parameter int         ADDR_W      = 8,
    parameter int         DATA_W      = 32,
    parameter int         WAIT_CYCLES = 1,
    parameter logic [3:0] TIMER_BASE  = 4'hF
) (
    input  logic              clk,
    input  logic              resetb,
    io_bus_arbiter_if.slave   m0,
    io_bus_arbiter_if.slave   m1,
    output logic [ADDR_W-1:0] io_addr,
    output logic              io_en,
    output logic              io_we,
    output logic [DATA_W-1:0] io_data_write,
    input  logic [DATA_W-1:0] io_data_read,
    output logic              mtime_we,
    input  logic [DATA_W-1:0] mtime_dout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

    state_t            state;
    state_t            state_nxt;
    logic              grant;
    logic              last_grant;
    logic              we_q;
    logic [3:0]        wait_cnt;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rd_src;
    logic              sel;
    logic              start;
    logic              last_access;
    logic              first_access;
    logic              timer_hit;

    assign timer_hit    = (io_addr[ADDR_W-1 -: 4] == TIMER_BASE);
    assign first_access = (wait_cnt == 4'd0);
    assign rd_src       = timer_hit ? mtime_dout : io_data_read;
    assign m0.rdata     = rdata0;
    assign m1.rdata     = rdata1;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        sel         = last_grant;
        start       = 1'b0;
        last_access = 1'b0;
        io_en       = 1'b0;
        io_we       = 1'b0;
        mtime_we    = 1'b0;
        m0.ack      = 1'b0;
        m1.ack      = 1'b0;
        case (state)
            IDLE: begin
                if (m0.req || m1.req) begin
                    start     = 1'b1;
                    // with both pending, the master that did not win last time goes next
                    sel       = (m0.req && m1.req) ? ~last_grant : m1.req;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                io_en    = !timer_hit;
                io_we    = !timer_hit && we_q && first_access;
                mtime_we = timer_hit && we_q && first_access;
                if (wait_cnt == WAIT_LAST) begin
                    last_access = 1'b1;
                    state_nxt   = DONE;
                end
            end
            DONE: begin
                m0.ack    = !grant;
                m1.ack    = grant;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            grant         <= 1'b0;
            last_grant    <= 1'b1;
            we_q          <= 1'b0;
            wait_cnt      <= 4'd0;
            io_addr       <= '0;
            io_data_write <= '0;
            rdata0        <= '0;
            rdata1        <= '0;
        end else begin
            if (start) begin
                grant         <= sel;
                last_grant    <= sel;
                we_q          <= sel ? m1.we    : m0.we;
                io_addr       <= sel ? m1.addr  : m0.addr;
                io_data_write <= sel ? m1.wdata : m0.wdata;
                wait_cnt      <= 4'd0;
            end else if (state == ACCESS && wait_cnt != WAIT_LAST) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
            if (last_access && !we_q) begin
                if (grant) begin
                    rdata1 <= rd_src;
                end else begin
                    rdata0 <= rd_src;
                end
            end
        end
    end

endmodule
